// File: rtl/serial_adder_n.sv
// serial_adder_n: multi-cycle WIDTH-bit adder/subtractor. A shared STEP-bit ripple slice
// processes the operands LSB first, one slice per clock, over N = WIDTH/STEP passes.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only while busy = 0
//   A, B   - operands, captured on the accepting edge
//   Ci     - carry-in (add) / borrow-in (sub), captured on the accepting edge
//   Sub    - 0: A+B+Ci, 1: A-B-Ci, captured on the accepting edge
//   busy   - operation in progress
//   done   - one-cycle pulse, So/Co/Ovf valid
//   So     - sum/difference, held until the next completed operation
//   Co     - add: carry-out; sub: 1 = no borrow
//   Ovf    - two's-complement overflow
module serial_adder_n #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] So,
  output logic             Co,
  output logic             Ovf
);

  localparam int unsigned N    = WIDTH / STEP;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [WIDTH-1:0]  r_op_a, w_op_a_d;
  logic [WIDTH-1:0]  r_op_b, w_op_b_d;
  logic [WIDTH-1:0]  r_res, w_res_d;
  logic [WIDTH-1:0]  r_so, w_so_d;
  logic              r_carry, w_carry_d;
  logic              r_co, w_co_d;
  logic              r_ovf, w_ovf_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;

  logic [STEP:0]     w_slice;
  logic [WIDTH-1:0]  w_slice_ext;
  logic [WIDTH-1:0]  w_res_shift;
  logic              w_msb_cin;

  always_comb begin
    w_slice = {1'b0, r_op_a[STEP-1:0]} + {1'b0, r_op_b[STEP-1:0]} + {{STEP{1'b0}}, r_carry};
    // Carry into the slice MSB, recovered from its sum bit; meaningful on the last pass only.
    w_msb_cin = r_op_a[STEP-1] ^ r_op_b[STEP-1] ^ w_slice[STEP-1];
    w_slice_ext = '0;
    w_slice_ext[STEP-1:0] = w_slice[STEP-1:0];
    // New slice enters at the MSB side so the LSB slice ends up at bit 0 after N passes.
    w_res_shift = (r_res >> STEP) | (w_slice_ext << (WIDTH - STEP));
  end

  always_comb begin
    w_state_d = r_state;
    w_op_a_d  = r_op_a;
    w_op_b_d  = r_op_b;
    w_res_d   = r_res;
    w_carry_d = r_carry;
    w_cnt_d   = r_cnt;
    w_so_d    = r_so;
    w_co_d    = r_co;
    w_ovf_d   = r_ovf;
    unique case (r_state)
      StIdle, StDone: begin
        w_state_d = StIdle;
        if (start) begin
          w_state_d = StRun;
          w_op_a_d  = A;
          // Subtraction as A + ~B + ~borrow.
          w_op_b_d  = Sub ? ~B : B;
          w_carry_d = Ci ^ Sub;
          w_cnt_d   = CntW'(N - 1);
          w_res_d   = '0;
        end
      end
      StRun: begin
        w_op_a_d  = r_op_a >> STEP;
        w_op_b_d  = r_op_b >> STEP;
        w_res_d   = w_res_shift;
        w_carry_d = w_slice[STEP];
        w_cnt_d   = r_cnt - 1'b1;
        if (r_cnt == '0) begin
          w_cnt_d   = '0;
          w_so_d    = w_res_shift;
          w_co_d    = w_slice[STEP];
          w_ovf_d   = w_msb_cin ^ w_slice[STEP];
          w_state_d = StDone;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_so    <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_op_a  <= w_op_a_d;
      r_op_b  <= w_op_b_d;
      r_res   <= w_res_d;
      r_carry <= w_carry_d;
      r_cnt   <= w_cnt_d;
      r_so    <= w_so_d;
      r_co    <= w_co_d;
      r_ovf   <= w_ovf_d;
    end
  end

  assign busy = (r_state == StRun);
  assign done = (r_state == StDone);
  assign So   = r_so;
  assign Co   = r_co;
  assign Ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n: three instances (4/1, 1/1, 8/2), expected results
// computed arithmetically and queued at issue, checked by per-instance monitors on done.
module tb_serial_adder_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic       ci, sub;
  logic       st0, st1, st2;

  logic       busy0, done0, co0, ovf0;
  logic [3:0] so0;
  logic       busy1, done1, co1, ovf1;
  logic [0:0] so1;
  logic       busy2, done2, co2, ovf2;
  logic [7:0] so2;

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(4), .STEP(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .A(a[3:0]), .B(b[3:0]), .Ci(ci), .Sub(sub),
    .busy(busy0), .done(done0), .So(so0), .Co(co0), .Ovf(ovf0)
  );
  serial_adder_n #(.WIDTH(1), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .A(a[0:0]), .B(b[0:0]), .Ci(ci), .Sub(sub),
    .busy(busy1), .done(done1), .So(so1), .Co(co1), .Ovf(ovf1)
  );
  serial_adder_n #(.WIDTH(8), .STEP(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .A(a), .B(b), .Ci(ci), .Sub(sub),
    .busy(busy2), .done(done2), .So(so2), .Co(co2), .Ovf(ovf2)
  );

  typedef struct {
    int so;
    int co;
    int ovf;
    int cyc;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input int w, input int av, input int bv, input int civ,
                                 input int subv);
    exp_t e;
    int mask, ua, ub, r, sa, sb, sr, half;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ua = av & mask;
    ub = bv & mask;
    r = subv ? (ua - ub - civ) : (ua + ub + civ);
    e.so = r & mask;
    e.co = subv ? int'(r >= 0) : ((r >> w) & 1);
    sa = (ua >= half) ? ua - (1 << w) : ua;
    sb = (ub >= half) ? ub - (1 << w) : ub;
    sr = subv ? (sa - sb - civ) : (sa + sb + civ);
    e.ovf = int'((sr > half - 1) || (sr < -half));
    e.cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done0 === 1'b1) begin
      chk("m0_pending", int'(q0.size() != 0), 1);
      chk("m0_busy_low", int'(busy0), 0);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("m0_so", int'(so0), e.so);
        chk("m0_co", int'(co0), e.co);
        chk("m0_ovf", int'(ovf0), e.ovf);
        chk("m0_latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done1 === 1'b1) begin
      chk("m1_pending", int'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("m1_so", int'(so1), e.so);
        chk("m1_co", int'(co1), e.co);
        chk("m1_ovf", int'(ovf1), e.ovf);
        chk("m1_latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done2 === 1'b1) begin
      chk("m2_pending", int'(q2.size() != 0), 1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        chk("m2_so", int'(so2), e.so);
        chk("m2_co", int'(co2), e.co);
        chk("m2_ovf", int'(ovf2), e.ovf);
        chk("m2_latency", cyc, e.cyc);
      end
    end
  end

  task automatic get_busy(input int inst, output logic bz);
    case (inst)
      0: bz = busy0;
      1: bz = busy1;
      default: bz = busy2;
    endcase
  endtask

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: st0 = v;
      1: st1 = v;
      default: st2 = v;
    endcase
  endtask

  // Called at a negedge; issues one op and returns at the negedge after the accepting edge.
  task automatic op(input int inst, input int av, input int bv, input int civ, input int subv);
    exp_t e;
    logic bz;
    int   guard, w, n;
    w = (inst == 0) ? 4 : (inst == 1) ? 1 : 8;
    n = (inst == 1) ? 1 : 4;
    guard = 0;
    get_busy(inst, bz);
    while (bz && guard < 100) begin
      @(negedge clk);
      guard++;
      get_busy(inst, bz);
    end
    if (guard >= 100) chk("op_wait_idle_timeout", guard, 0);
    a = 8'(av);
    b = 8'(bv);
    ci = civ[0];
    sub = subv[0];
    set_start(inst, 1'b1);
    @(posedge clk);
    #1;
    e = model(w, av, bv, civ, subv);
    e.cyc = cyc + n;
    case (inst)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    @(negedge clk);
    set_start(inst, 1'b0);
    // Operand changes while running must not matter.
    a = 8'($urandom);
    b = 8'($urandom);
    ci = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // Returns at the first negedge with busy low (the DONE cycle for a just-issued op).
  task automatic wait_done(input int inst);
    logic bz;
    int   guard;
    guard = 0;
    get_busy(inst, bz);
    while (bz && guard < 100) begin
      @(negedge clk);
      guard++;
      get_busy(inst, bz);
    end
    if (guard >= 100) chk("wait_done_timeout", guard, 0);
  endtask

  task automatic run(input int inst, input int av, input int bv, input int civ,
                     input int subv);
    op(inst, av, bv, civ, subv);
    wait_done(inst);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    st0 = 1'b1; st1 = 1'b1; st2 = 1'b1;
    a = 8'hff; b = 8'hff; ci = 1'b1; sub = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_so0", int'(so0), 0);
    chk("rst_co0", int'(co0), 0);
    chk("rst_ovf0", int'(ovf0), 0);
    chk("rst_busy2", int'(busy2), 0);
    chk("rst_so2", int'(so2), 0);
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy0", int'(busy0), 0);
    chk("idle_done0", int'(done0), 0);

    // Directed add/subtract cases.
    run(0, 7, 1, 0, 0);
    run(0, 15, 0, 1, 0);
    run(0, 3, 5, 0, 1);
    run(0, 8, 1, 0, 1);
    run(0, 9, 4, 1, 1);

    // Start pulsed while busy is ignored; result persists through idle.
    op(0, 7, 1, 0, 0);
    a = 8'd1; b = 8'd1; ci = 1'b0; sub = 1'b0; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    wait_done(0);
    repeat (4) @(negedge clk);
    chk("hold_so0", int'(so0), 8);
    chk("hold_busy0", int'(busy0), 0);

    // Back-to-back: second op issued in the DONE cycle.
    op(0, 5, 6, 0, 0);
    wait_done(0);
    op(0, 9, 3, 1, 1);
    wait_done(0);
    op(0, 2, 12, 0, 0);
    wait_done(0);
    @(negedge clk);

    // Reset mid-operation aborts; the next op has no stale carry.
    op(0, 15, 15, 1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q0.delete();
    #1;
    chk("abort_busy0", int'(busy0), 0);
    chk("abort_done0", int'(done0), 0);
    chk("abort_so0", int'(so0), 0);
    chk("abort_co0", int'(co0), 0);
    chk("abort_ovf0", int'(ovf0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 1, 1, 0, 0);

    // WIDTH = 1: full-adder truth table, then subtract combos.
    for (int i = 0; i < 8; i++) run(1, (i >> 2) & 1, (i >> 1) & 1, i & 1, 0);
    for (int i = 0; i < 8; i++) run(1, (i >> 2) & 1, (i >> 1) & 1, i & 1, 1);

    // WIDTH = 8, STEP = 2.
    run(2, 200, 100, 1, 0);
    for (int i = 0; i < 25; i++) begin
      op(2, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
         int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      wait_done(2);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    @(negedge clk);

    // Random WIDTH = 4 vectors with occasional back-to-back issue.
    for (int i = 0; i < 25; i++) begin
      op(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
         int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      wait_done(0);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    guard = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
